// File: rtl/uart_result_collector_pkg.sv
// Shared types and constants for the UART result collector.
// Frame geometry defaults and the collector state encoding.
package uart_result_collector_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2,
        DONE    = 2'd3
    } coll_state_t;

    localparam int WORD_BYTES             = 4;
    localparam int DEFAULT_N              = 12;
    localparam int DEFAULT_TIMEOUT_CYCLES = 8192;

endpackage

// File: rtl/uart_result_collector_gap_timer.sv
// Inter-byte gap timer: counts enabled cycles, terminal pulse at TIMEOUT_CYCLES-1.
// Latency: tc is combinational from the count; clear (a new byte) always beats tc.
module uart_result_collector_gap_timer #(
    parameter int  TIMEOUT_CYCLES = 8192,
    localparam int CW             = $clog2(TIMEOUT_CYCLES)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tc    = enable && !clear && (cnt_q == TERM);
        cnt_d = cnt_q + CW'(1);
        if (clear || !enable || tc) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_result_collector.sv
// Rebuilds little-endian 32-bit result words from UART bytes, one N*N-word frame per start.
// Word valid 1 clk after its last byte; output holds until accepted, a word completing against a stalled one is dropped.
module uart_result_collector
    import uart_result_collector_pkg::*;
#(
    parameter int  N              = DEFAULT_N,
    parameter int  TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    localparam int IDX_W          = $clog2(N * N)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             rx_done_tick,
    input  logic [7:0]       rx_data,
    output logic             word_valid,
    input  logic             word_ready,
    output logic [31:0]      word_data,
    output logic [IDX_W-1:0] word_index,
    output logic             busy,
    output logic             frame_done,
    output logic             err_timeout,
    output logic             err_overflow,
    input  logic             clear_err
);

    localparam int WORDS = N * N;
    localparam int CNT_W = $clog2(WORDS + 1);
    localparam int BC_W  = $clog2(WORD_BYTES);
    localparam int SH_W  = 8 * WORD_BYTES;

    localparam logic [BC_W-1:0]  LAST_BYTE = BC_W'(WORD_BYTES - 1);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);
    localparam logic [CNT_W-1:0] ALL_WORDS = CNT_W'(WORDS);

    coll_state_t      state_q, state_d;
    logic [BC_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [SH_W-1:0]  shreg_q, shreg_d;
    logic             word_valid_q, word_valid_d;
    logic [31:0]      word_data_q, word_data_d;
    logic [IDX_W-1:0] word_index_q, word_index_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;
    logic             err_timeout_q, err_timeout_d;
    logic             err_overflow_q, err_overflow_d;

    logic             gap_tc;
    logic             gap_en;
    logic             accept;
    logic             to_set;
    logic             ov_set;
    logic [SH_W-1:0]  assembled;

    // The timer only runs while a partial word is sitting in the packer.
    assign gap_en = (state_q == COLLECT) && (byte_cnt_q != '0);

    uart_result_collector_gap_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (rx_done_tick),
        .enable  (gap_en),
        .tc      (gap_tc)
    );

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        word_cnt_d   = word_cnt_q;
        shreg_d      = shreg_q;
        word_valid_d = word_valid_q;
        word_data_d  = word_data_q;
        word_index_d = word_index_q;
        to_set       = 1'b0;
        ov_set       = 1'b0;
        accept       = word_valid_q && word_ready;

        assembled                      = shreg_q;
        assembled[8*byte_cnt_q +: 8]   = rx_data;

        if (accept) begin
            word_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (rx_done_tick) begin
                    shreg_d = assembled;
                    if (byte_cnt_q == LAST_BYTE) begin
                        byte_cnt_d = '0;
                        word_cnt_d = word_cnt_q + CNT_W'(1);
                        // An accept in this same cycle frees the slot, so the new word replaces it.
                        if (word_valid_q && !word_ready) begin
                            ov_set = 1'b1;
                        end else begin
                            word_valid_d = 1'b1;
                            word_data_d  = assembled;
                            word_index_d = word_cnt_q[IDX_W-1:0];
                        end
                        if (word_cnt_q == LAST_WORD) begin
                            state_d = HOLD;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + BC_W'(1);
                    end
                end else if (gap_tc) begin
                    byte_cnt_d = '0;
                    to_set     = 1'b1;
                end
            end
            HOLD: begin
                if (accept && (word_cnt_q == ALL_WORDS)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d    = IDLE;
                word_cnt_d = '0;
            end
        endcase

        err_timeout_d  = (err_timeout_q && !clear_err) || to_set;
        err_overflow_d = (err_overflow_q && !clear_err) || ov_set;
        busy_d         = (state_d == COLLECT) || (state_d == HOLD);
        frame_done_d   = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            byte_cnt_q     <= '0;
            word_cnt_q     <= '0;
            shreg_q        <= '0;
            word_valid_q   <= 1'b0;
            word_data_q    <= '0;
            word_index_q   <= '0;
            busy_q         <= 1'b0;
            frame_done_q   <= 1'b0;
            err_timeout_q  <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            byte_cnt_q     <= byte_cnt_d;
            word_cnt_q     <= word_cnt_d;
            shreg_q        <= shreg_d;
            word_valid_q   <= word_valid_d;
            word_data_q    <= word_data_d;
            word_index_q   <= word_index_d;
            busy_q         <= busy_d;
            frame_done_q   <= frame_done_d;
            err_timeout_q  <= err_timeout_d;
            err_overflow_q <= err_overflow_d;
        end
    end

    assign word_valid   = word_valid_q;
    assign word_data    = word_data_q;
    assign word_index   = word_index_q;
    assign busy         = busy_q;
    assign frame_done   = frame_done_q;
    assign err_timeout  = err_timeout_q;
    assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_uart_result_collector.sv
// Bench for uart_result_collector: directed byte streams, a frame-level reference model
// compared every cycle, and literal expectations for the accepted words of each scenario.
module tb_uart_result_collector;

    localparam int N     = 2;
    localparam int T     = 8192;
    localparam int IDX_W = $clog2(N * N);

    logic             clk;
    logic             reset_n;
    logic             start;
    logic             rx_done_tick;
    logic [7:0]       rx_data;
    logic             word_valid;
    logic             word_ready;
    logic [31:0]      word_data;
    logic [IDX_W-1:0] word_index;
    logic             busy;
    logic             frame_done;
    logic             err_timeout;
    logic             err_overflow;
    logic             clear_err;

    uart_result_collector #(
        .N              (N),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .rx_done_tick (rx_done_tick),
        .rx_data      (rx_data),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .word_data    (word_data),
        .word_index   (word_index),
        .busy         (busy),
        .frame_done   (frame_done),
        .err_timeout  (err_timeout),
        .err_overflow (err_overflow),
        .clear_err    (clear_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: frame-level view of the byte stream.
    bit               m_live = 0;
    bit               m_collect, m_hold, m_done, m_valid, m_to, m_ov;
    logic [31:0]      m_data;
    logic [IDX_W-1:0] m_idx;
    int               m_words;
    int               gap;
    logic [7:0]       part[$];

    task automatic model_step();
        bit          acc;
        bit          was_valid;
        bit          to_set;
        bit          ov_set;
        logic [31:0] w;
        was_valid = m_valid;
        acc       = m_valid && word_ready;
        to_set    = 0;
        ov_set    = 0;
        if (!reset_n) begin
            m_collect = 0; m_hold = 0; m_done = 0; m_valid = 0; m_to = 0; m_ov = 0;
            m_data = '0; m_idx = '0; m_words = 0; gap = 0;
            part.delete();
        end else begin
            if (acc) m_valid = 0;
            if (m_done) begin
                m_done  = 0;
                m_words = 0;
            end else if (m_hold) begin
                if (acc) begin
                    m_hold = 0;
                    m_done = 1;
                end
            end else if (m_collect) begin
                if (rx_done_tick) begin
                    part.push_back(rx_data);
                    gap = 0;
                    if (part.size() == 4) begin
                        w = {part[3], part[2], part[1], part[0]};
                        part.delete();
                        if (was_valid && !word_ready) begin
                            ov_set = 1;
                        end else begin
                            m_valid = 1;
                            m_data  = w;
                            m_idx   = m_words[IDX_W-1:0];
                        end
                        m_words++;
                        if (m_words == N * N) begin
                            m_collect = 0;
                            m_hold    = 1;
                        end
                    end
                end else if (part.size() > 0) begin
                    if (gap == T - 1) begin
                        part.delete();
                        gap    = 0;
                        to_set = 1;
                    end else begin
                        gap++;
                    end
                end
            end else if (start) begin
                m_collect = 1;
            end
            m_to = (m_to && !clear_err) || to_set;
            m_ov = (m_ov && !clear_err) || ov_set;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            m_live = 1;
        end
    end

    // Every-cycle compare plus a log of accepted words and frame_done pulses.
    logic [31:0] acc_data[$];
    int          acc_idx[$];
    int          done_cnt = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (m_live) begin
                check("word_valid", {31'd0, word_valid}, {31'd0, m_valid});
                if (m_valid) begin
                    check("word_data", word_data, m_data);
                    check("word_index", {{(32-IDX_W){1'b0}}, word_index}, {{(32-IDX_W){1'b0}}, m_idx});
                end
                check("busy", {31'd0, busy}, {31'd0, (m_collect || m_hold)});
                check("frame_done", {31'd0, frame_done}, {31'd0, m_done});
                check("err_timeout", {31'd0, err_timeout}, {31'd0, m_to});
                check("err_overflow", {31'd0, err_overflow}, {31'd0, m_ov});
            end
            if (word_valid === 1'b1 && word_ready === 1'b1) begin
                acc_data.push_back(word_data);
                acc_idx.push_back(int'(word_index));
            end
            if (frame_done === 1'b1) done_cnt++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_done_tick = 1'b1;
        rx_data      = b;
        @(posedge clk);
        #1;
        rx_done_tick = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send(w[8*k +: 8]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic clear_log();
        acc_data.delete();
        acc_idx.delete();
    endtask

    task automatic check_acc(input string name, input int i, input logic [31:0] d, input int x);
        if (i < acc_data.size()) begin
            check({name, "_data"}, acc_data[i], d);
            check({name, "_idx"}, acc_idx[i], x);
        end else begin
            check({name, "_missing"}, acc_data.size(), i + 1);
        end
    endtask

    task automatic wait_done(input string name, input int max);
        int d0 = done_cnt;
        int k  = 0;
        while (done_cnt == d0 && k < max) begin
            cyc(1);
            k++;
        end
        cyc(2);
        check(name, done_cnt - d0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        reset_n = 1'b0; start = 1'b0; rx_done_tick = 1'b0; rx_data = '0;
        word_ready = 1'b0; clear_err = 1'b0;
        cyc(3);
        reset_n = 1'b1;
        check("rst_valid", {31'd0, word_valid}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_data", word_data, 0);
        check("rst_errs", {30'd0, err_timeout, err_overflow}, 0);

        // Basic frame, consumer always ready.
        word_ready = 1'b1; clear_log(); pulse_start();
        send_word(32'h12345678); send_word(32'hDEADBEEF);
        send_word(32'h00000001); send_word(32'hFFFFFFFF);
        wait_done("t1_done", 20);
        check_acc("t1_w0", 0, 32'h12345678, 0);
        check_acc("t1_w1", 1, 32'hDEADBEEF, 1);
        check_acc("t1_w2", 2, 32'h00000001, 2);
        check_acc("t1_w3", 3, 32'hFFFFFFFF, 3);

        // Overflow: second word completes against a stalled first one.
        word_ready = 1'b0; clear_log(); pulse_start();
        send_word(32'h44332211); send_word(32'h88776655);
        cyc(1);
        check("t2_ovf", {31'd0, err_overflow}, 1);
        check("t2_kept", word_data, 32'h44332211);
        word_ready = 1'b1;
        send_word(32'hCCBBAA99); send_word(32'h00FFEEDD);
        wait_done("t2_done", 20);
        check("t2_nacc", acc_data.size(), 3);
        check_acc("t2_w0", 0, 32'h44332211, 0);
        check_acc("t2_w2", 1, 32'hCCBBAA99, 2);
        clear_err = 1'b1; cyc(1); clear_err = 1'b0;
        check("t2_clr", {31'd0, err_overflow}, 0);

        // Gap timeout after two bytes, then a gap one cycle short of it.
        word_ready = 1'b1; clear_log(); pulse_start();
        send(8'h01); send(8'h02);
        cyc(T);
        check("t3_timeout", {31'd0, err_timeout}, 1);
        send_word(32'hDDCCBBAA);
        clear_err = 1'b1; cyc(1); clear_err = 1'b0;
        send(8'h10); cyc(T - 1); send(8'h20); send(8'h30); send(8'h40);
        check("t3_edge_no_to", {31'd0, err_timeout}, 0);
        send_word(32'h00000005); send_word(32'h00000006);
        wait_done("t3_done", 20);
        check_acc("t3_w0", 0, 32'hDDCCBBAA, 0);
        check_acc("t3_w1", 1, 32'h40302010, 1);

        // Bytes outside a frame are ignored.
        clear_log();
        send_word(32'hBAD0BAD0);
        check("t4_idle_valid", {31'd0, word_valid}, 0);
        d0 = done_cnt;
        pulse_start();
        send_word(32'hA1A2A3A4); send_word(32'hB1B2B3B4);
        send_word(32'hC1C2C3C4); send_word(32'hD1D2D3D4);
        for (int k = 0; k < 6; k++) send(8'hEE);
        cyc(2);
        check("t4_done", done_cnt - d0, 1);
        check("t4_nacc", acc_data.size(), 4);
        check_acc("t4_w3", 3, 32'hD1D2D3D4, 3);
        clear_log(); pulse_start();
        send_word(32'h11111111); send_word(32'h22222222);
        send_word(32'h33333333); send_word(32'h44444444);
        wait_done("t4b_done", 20);
        check_acc("t4b_w0", 0, 32'h11111111, 0);

        // Reset mid-frame.
        word_ready = 1'b0; pulse_start();
        send_word(32'h5A5A5A5A); send(8'h77);
        d0 = done_cnt;
        reset_n = 1'b0; cyc(1); reset_n = 1'b1;
        check("t5_valid", {31'd0, word_valid}, 0);
        check("t5_data", word_data, 0);
        check("t5_busy", {31'd0, busy}, 0);
        word_ready = 1'b1; clear_log(); pulse_start();
        send_word(32'hCAFEF00D); send_word(32'h0BADBEEF);
        send_word(32'h13572468); send_word(32'h80000001);
        wait_done("t5_done", 20);
        check_acc("t5_w0", 0, 32'hCAFEF00D, 0);
        check_acc("t5_w3", 3, 32'h80000001, 3);

        // Accept and completion in the same cycle.
        word_ready = 1'b0; clear_log(); pulse_start();
        send_word(32'h04030201);
        send(8'h05); send(8'h06); send(8'h07);
        word_ready = 1'b1; send(8'h08); word_ready = 1'b0;
        check("t6_valid", {31'd0, word_valid}, 1);
        check("t6_data", word_data, 32'h08070605);
        check("t6_idx", {{(32-IDX_W){1'b0}}, word_index}, 1);
        check("t6_no_ovf", {31'd0, err_overflow}, 0);
        cyc(1);
        word_ready = 1'b1;
        send_word(32'h0C0B0A09); send_word(32'h100F0E0D);
        wait_done("t6_done", 20);
        check_acc("t6_w0", 0, 32'h04030201, 0);
        check_acc("t6_w1", 1, 32'h08070605, 1);
        check_acc("t6_w3", 3, 32'h100F0E0D, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
